// File: rtl/queue_uart_tx.sv
// Queue-drain UART transmitter: pops one word per frame from the sample queue and
// sends it as start, NBITS data (LSB first), optional parity and STOP_BITS stop bits.
module queue_uart_tx #(
    parameter int NBITS        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             em,
    input  logic [NBITS-1:0] q_data,
    output logic             pp,
    output logic             tx,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(NBITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] PAR   = 3'd5;
    localparam logic [2:0] STOP  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              pp_q, pp_d;
    logic              busy_q, busy_d;
    logic              timed;
    logic              bit_end;

    // Pop handshake: pp is a one-cycle strobe and the queue pops on the edge that
    // ends it; q_data is then valid during LOAD and is captured on LOAD's exit edge.
    assign timed   = (state_q == START) || (state_q == DATA) ||
                     (state_q == PAR)   || (state_q == STOP);
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (en && !em) state_d = POP;
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = q_data;
                par_d   = (PARITY == 2) ? ~(^q_data) : ^q_data;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) state_d = IDLE;
                    else                    bit_d   = bit_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Baud counter restarts on every bit boundary, so a frame never drifts.
    assign baud_d = (timed && !bit_end) ? baud_q + 1'b1 : '0;

    always_comb begin
        pp_d   = (state_d == POP);
        busy_d = (state_d != IDLE);
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_q[0];
            PAR:     tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            pp_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            pp_q    <= pp_d;
            busy_q  <= busy_d;
        end
    end

    assign pp        = pp_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_queue_uart_tx.sv
// Bench for queue_uart_tx: three instances (no/even/odd parity, 1/1/2 stop bits)
// fed from bench-side queues, checked against a frame-level waveform model.
module tb_queue_uart_tx;

    localparam int CPB = 4;

    logic       ck = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic [2:0] em_v;
    logic [2:0] pp_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] st_dbg [3];

    logic [7:0] mem [3][32];
    int         tail [3];
    int         mrd [3];
    int         pp_cnt [3];
    logic [2:0] exp_q [3][$];

    int checks   = 0;
    int failures = 0;

    always #5 ck = ~ck;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] qd   = 8'h00;
        int         head = 0;
        logic       em_l;

        assign em_l    = (head == tail[g]);
        assign em_v[g] = em_l;

        always @(posedge ck) begin
            if (pp_v[g]) begin
                qd   <= mem[g][head];
                head <= head + 1;
            end
        end

        queue_uart_tx #(
            .NBITS(8), .CLKS_PER_BIT(CPB), .PARITY(g), .STOP_BITS((g == 2) ? 2 : 1)
        ) u_dut (
            .ck(ck), .rst(rst), .en(en[g]), .em(em_l), .q_data(qd),
            .pp(pp_v[g]), .tx(tx_v[g]), .busy(busy_v[g]), .state_dbg(st_dbg[g])
        );
    end

    function automatic int par_cfg(int i);
        return i;
    endfunction

    function automatic int stop_cfg(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic push_word(int i, logic [7:0] w);
        mem[i][tail[i]] = w;
        tail[i] = tail[i] + 1;
    endtask

    // Expected {pp,busy,tx} per cycle, starting with the cycle after the pop decision.
    task automatic push_frame(int i, logic [7:0] w);
        logic lv [16];
        int   n;
        n = 0;
        lv[n] = 1'b0; n++;
        for (int b = 0; b < 8; b++) begin
            lv[n] = w[b]; n++;
        end
        if (par_cfg(i) == 1) begin
            lv[n] = ^w; n++;
        end else if (par_cfg(i) == 2) begin
            lv[n] = ~(^w); n++;
        end
        for (int s = 0; s < stop_cfg(i); s++) begin
            lv[n] = 1'b1; n++;
        end
        exp_q[i].push_back(3'b111);
        exp_q[i].push_back(3'b011);
        exp_q[i].push_back(3'b011);
        for (int c = 3; c <= 1 + n * CPB; c++) exp_q[i].push_back({2'b01, lv[(c - 3) / CPB]});
    endtask

    task automatic step();
        logic [2:0] cur;
        logic [2:0] got;
        logic [2:0] dummy;
        @(negedge ck);
        for (int i = 0; i < 3; i++) begin
            cur = (exp_q[i].size() != 0) ? exp_q[i][0] : 3'b001;
            got = {pp_v[i], busy_v[i], tx_v[i]};
            checks++;
            if (got !== cur) begin
                failures++;
                $display("FAIL model_cmp inst%0d t=%0t got pp/busy/tx=%b exp=%b", i, $time, got, cur);
            end
            if (pp_v[i]) pp_cnt[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            if (exp_q[i].size() != 0) begin
                dummy = exp_q[i].pop_front();
            end else if (!rst && en[i] && !em_v[i]) begin
                push_frame(i, mem[i][mrd[i]]);
                mrd[i]++;
            end
        end
        @(posedge ck);
        #1;
    endtask

    logic [9:0] t1_exp;
    logic       tx_hist [120];
    int         base_pp;
    int         base_pp2;
    int         f1;
    int         f2;
    int         ones;

    initial begin
        rst = 1'b1;
        en  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tail[i]   = 0;
            mrd[i]    = 0;
            pp_cnt[i] = 0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_tx", int'(tx_v[i]), 1);
            check("reset_pp", int'(pp_v[i]), 0);
            check("reset_busy", int'(busy_v[i]), 0);
            check("reset_state", int'(st_dbg[i]), 0);
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // T1: single 0xA5 frame, no parity
        t1_exp = 10'b0101001011;
        base_pp = pp_cnt[0];
        push_word(0, 8'hA5);
        en[0] = 1'b1;
        for (int m = 1; m <= 50; m++) begin
            step();
            if (m == 1) check("t1_pp_first", int'(pp_v[0]), 1);
            if (m == 2) check("t1_pp_single", int'(pp_v[0]), 0);
            if (m == 3) check("t1_tx_before_start", int'(tx_v[0]), 1);
            if (m >= 4 && m <= 40 && (m % 4) == 0)
                check("t1_bit", int'(tx_v[0]), int'(t1_exp[9 - (m - 4) / 4]));
        end
        check("t1_pp_count", pp_cnt[0] - base_pp, 1);
        check("t1_em_after", int'(em_v[0]), 1);

        // T3: back-to-back 0x11, 0x22
        base_pp = pp_cnt[0];
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        for (int m = 1; m < 120; m++) begin
            step();
            tx_hist[m] = tx_v[0];
        end
        tx_hist[0] = 1'b1;
        f1 = -1;
        f2 = -1;
        for (int m = 1; m < 120; m++) begin
            if (f1 < 0 && tx_hist[m] == 1'b0 && tx_hist[m - 1] == 1'b1) f1 = m;
        end
        for (int m = 1; m < 120; m++) begin
            if (f1 >= 0 && f2 < 0 && m >= f1 + 40 && tx_hist[m] == 1'b0 && tx_hist[m - 1] == 1'b1) f2 = m;
        end
        check("t3_first_start", f1, 4);
        check("t3_frame_period", f2 - f1, 43);
        ones = 0;
        if (f2 >= 8) begin
            for (int m = f2 - 7; m < f2; m++) ones += int'(tx_hist[m]);
            check("t3_gap_ones", ones, 7);
            check("t3_gap_lead", int'(tx_hist[f2 - 8]), 0);
        end else begin
            check("t3_second_start_found", f2, 47);
        end
        check("t3_pp_count", pp_cnt[0] - base_pp, 2);
        check("t3_em_after", int'(em_v[0]), 1);

        // T4: enable held low with data waiting
        en[0] = 1'b0;
        base_pp = pp_cnt[0];
        push_word(0, 8'h3C);
        repeat (100) step();
        check("t4_pp_held", pp_cnt[0] - base_pp, 0);
        check("t4_tx_idle", int'(tx_v[0]), 1);
        check("t4_busy_idle", int'(busy_v[0]), 0);
        en[0] = 1'b1;
        repeat (50) step();
        check("t4_pp_after_en", pp_cnt[0] - base_pp, 1);

        // T5: reset in DATA bit 3, then the remaining word goes out whole
        base_pp = pp_cnt[0];
        push_word(0, 8'h5A);
        push_word(0, 8'hC3);
        repeat (21) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        #1;
        check("t5_rst_tx", int'(tx_v[0]), 1);
        check("t5_rst_pp", int'(pp_v[0]), 0);
        check("t5_rst_busy", int'(busy_v[0]), 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (60) step();
        check("t5_pp_count", pp_cnt[0] - base_pp, 2);
        check("t5_em_after", int'(em_v[0]), 1);

        // T2 + T6: 0x07 with even/odd parity; two stop bits on inst2; en drops in DATA
        en[0] = 1'b0;
        base_pp  = pp_cnt[1];
        base_pp2 = pp_cnt[2];
        push_word(1, 8'h07);
        push_word(1, 8'h55);
        push_word(2, 8'h07);
        push_word(2, 8'h55);
        en[1] = 1'b1;
        en[2] = 1'b1;
        for (int m = 1; m <= 100; m++) begin
            step();
            if (m == 40) begin
                check("t2_even_parity", int'(tx_v[1]), 1);
                check("t2_odd_parity", int'(tx_v[2]), 0);
            end
            if (m == 44) check("t6_stop1", int'(tx_v[2]), 1);
            if (m == 46) check("t2_busy_last", int'(busy_v[1]), 1);
            if (m == 47) check("t2_busy_end", int'(busy_v[1]), 0);
            if (m == 50) check("t6_busy_last", int'(busy_v[2]), 1);
            if (m == 51) check("t6_busy_end", int'(busy_v[2]), 0);
            if (m == 20) en[2:1] = 2'b00;
        end
        check("t6_pp_count_even", pp_cnt[1] - base_pp, 1);
        check("t6_pp_count_odd", pp_cnt[2] - base_pp2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
